// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: maximum supported width and binary/Gray conversion helpers.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] value);
    return value ^ (value >> 1);
  endfunction

  // Prefix XOR from the MSB down; bit i of the result is the XOR of value[MSB:i].
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] value);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = value[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ value[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray encoder, one XOR per bit below the MSB.
module gray_encode #(
  parameter int size = 8
) (
  input  logic [size-1:0] bin,
  output logic [size-1:0] gray
);

  genvar gi;
  generate
    for (gi = 0; gi < size - 1; gi++) begin : g_bit
      assign gray[gi] = bin[gi] ^ bin[gi+1];
    end
  endgenerate

  assign gray[size-1] = bin[size-1];

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with cycle-aligned registered Gray output and terminal-count flag.
// Define GRAY_CNT_SAT_EN to saturate at the limits instead of wrapping.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [size-1:0] load_val,
  input  logic            en,
  input  logic            up,
  output logic [size-1:0] bin_out,
  output logic [size-1:0] gray_out,
  output logic            tc
);

  localparam logic [size-1:0] cnt_one = {{(size-1){1'b0}}, 1'b1};
  localparam logic [size-1:0] cnt_max = '1;

  logic [size-1:0] bin_reg, bin_next;
  logic [size-1:0] gray_reg, gray_next;
  logic            tc_reg, tc_next;

  // Priority mux: clr > load > en; rst is handled in the register.
  always_comb begin
    bin_next = bin_reg;
    tc_next  = 1'b0;
    if (clr) begin
      bin_next = '0;
    end else if (load) begin
      bin_next = load_val;
    end else if (en) begin
      if (up) begin
`ifdef GRAY_CNT_SAT_EN
        if (bin_reg == cnt_max) tc_next = 1'b1;
        else                    bin_next = bin_reg + cnt_one;
`else
        bin_next = bin_reg + cnt_one;
        tc_next  = (bin_reg == cnt_max);
`endif
      end else begin
`ifdef GRAY_CNT_SAT_EN
        if (bin_reg == '0) tc_next = 1'b1;
        else               bin_next = bin_reg - cnt_one;
`else
        bin_next = bin_reg - cnt_one;
        tc_next  = (bin_reg == '0);
`endif
      end
    end
  end

  // Encoding the next value keeps gray_out aligned with bin_out.
  gray_encode #(
    .size(size)
  ) u_gray_encode (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      tc_reg   <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      tc_reg   <= tc_next;
    end
  end

  assign bin_out  = bin_reg;
  assign gray_out = gray_reg;
  assign tc       = tc_reg;

endmodule
